// File: rtl/dsp_pkg.sv
// Shared OPMODE bit positions and X/Z post-adder mux encodings for the DSP slice.
// No logic; constants and enums only.
// Backpressure: n/a.
package dsp_pkg;

    localparam int OP_X_LO   = 0;
    localparam int OP_Z_LO   = 2;
    localparam int OP_PREADD = 4;
    localparam int OP_CIN    = 5;
    localparam int OP_PRESUB = 6;
    localparam int OP_SUB    = 7;

    typedef enum logic [1:0] {
        X_ZERO = 2'd0,
        X_M    = 2'd1,
        X_P    = 2'd2,
        X_DAB  = 2'd3
    } xsel_e;

    typedef enum logic [1:0] {
        Z_ZERO = 2'd0,
        Z_PCIN = 2'd1,
        Z_P    = 2'd2,
        Z_C    = 2'd3
    } zsel_e;

endpackage

// File: rtl/dsp_pipe_reg.sv
// Optional pipeline register: clears on rst, loads on ce; EN=0 collapses it to a wire.
// Latency: EN cycles.
// Backpressure: ce=0 holds the stored value.
module dsp_pipe_reg #(
    parameter int W  = 1,
    parameter int EN = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    if (EN != 0) begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                q <= '0;
            else if (ce)
                q <= d;
        end
    end else begin : g_wire
        assign q = d;
    end

endmodule

// File: rtl/dsp_mac_pipe.sv
// DSP48A1-style slice: pre-adder, unsigned multiplier, post-adder/accumulator with optional saturation.
// Latency: AREG+MREG+1 ce-cycles from in_valid to out_valid; opmode/carryin travel with the sample.
// Backpressure: none; ce=0 freezes every stage including the valid tags.
module dsp_mac_pipe
    import dsp_pkg::*;
#(
    parameter int A_W    = 18,
    parameter int B_W    = 18,
    parameter int P_W    = 48,
    parameter int AREG   = 1,
    parameter int MREG   = 1,
    parameter int SAT_EN = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               in_valid,
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    input  logic [B_W-1:0]     d,
    input  logic [P_W-1:0]     c,
    input  logic [P_W-1:0]     pcin,
    input  logic               carryin,
    input  logic [7:0]         opmode,
    output logic               out_valid,
    output logic [B_W-1:0]     bcout,
    output logic [A_W+B_W-1:0] m,
    output logic [P_W-1:0]     p,
    output logic [P_W-1:0]     pcout,
    output logic               carryout,
    output logic               overflow
);

    localparam int M_W  = A_W + B_W;
    localparam int S_W  = P_W + 1;
    localparam int S1_W = 1 + 8 + 1 + A_W + 2*B_W + 2*P_W;
    localparam int S2_W = 7 + M_W + A_W + 2*B_W + 2*P_W;

    logic             s1_vld, s1_cy, s1_cin;
    logic [7:0]       s1_op;
    logic [A_W-1:0]   s1_a;
    logic [B_W-1:0]   s1_b, s1_d, bp;
    logic [P_W-1:0]   s1_c, s1_pcin;
    logic [M_W-1:0]   mul;
    logic [S1_W-1:0]  s1_q;

    dsp_pipe_reg #(.W(S1_W), .EN(AREG)) u_s1 (
        .clk(clk), .rst(rst), .ce(ce),
        .d({in_valid, opmode, carryin, a, b, d, c, pcin}),
        .q(s1_q)
    );
    assign {s1_vld, s1_op, s1_cy, s1_a, s1_b, s1_d, s1_c, s1_pcin} = s1_q;

    always_comb begin
        bp = s1_b;
        if (s1_op[OP_PREADD])
            bp = s1_op[OP_PRESUB] ? s1_d - s1_b : s1_d + s1_b;
    end

    assign mul    = M_W'(s1_a) * M_W'(bp);
    assign s1_cin = s1_op[OP_CIN] & s1_cy;
    assign bcout  = bp;

    // Only the opmode bits the post-adder still needs ride along past S1.
    logic             s2_vld, s2_sub, s2_cin;
    logic [1:0]       s2_xsel, s2_zsel;
    logic [M_W-1:0]   s2_m;
    logic [A_W-1:0]   s2_a;
    logic [B_W-1:0]   s2_b, s2_d;
    logic [P_W-1:0]   s2_c, s2_pcin;
    logic [S2_W-1:0]  s2_q;

    dsp_pipe_reg #(.W(S2_W), .EN(MREG)) u_s2 (
        .clk(clk), .rst(rst), .ce(ce),
        .d({s1_vld, s1_op[OP_SUB], s1_op[OP_Z_LO +: 2], s1_op[OP_X_LO +: 2], s1_cin,
            mul, s1_a, s1_b, s1_d, s1_c, s1_pcin}),
        .q(s2_q)
    );
    assign {s2_vld, s2_sub, s2_zsel, s2_xsel, s2_cin, s2_m, s2_a, s2_b, s2_d, s2_c, s2_pcin} = s2_q;
    assign m = s2_m;

    logic [P_W-1:0]   xv, zv, pn, p_q;
    logic [S_W-1:0]   sum;
    logic [P_W+1:0]   s3_q;

    always_comb begin
        case (xsel_e'(s2_xsel))
            X_ZERO:  xv = '0;
            X_M:     xv = P_W'(s2_m);
            X_P:     xv = p_q;
            default: xv = P_W'({s2_d, s2_a, s2_b});
        endcase
        case (zsel_e'(s2_zsel))
            Z_ZERO:  zv = '0;
            Z_PCIN:  zv = s2_pcin;
            Z_P:     zv = p_q;
            default: zv = s2_c;
        endcase
        if (s2_sub)
            sum = S_W'(zv) - (S_W'(xv) + S_W'(s2_cin));
        else
            sum = S_W'(zv) + S_W'(xv) + S_W'(s2_cin);
        // Top sum bit is carry on add and borrow on subtract; clamp in the matching direction.
        pn = sum[P_W-1:0];
        if (SAT_EN != 0 && sum[P_W])
            pn = s2_sub ? '0 : '1;
    end

    // Accumulator loads only on valid samples, so bubbles leave p untouched.
    dsp_pipe_reg #(.W(P_W+2), .EN(1)) u_s3 (
        .clk(clk), .rst(rst), .ce(ce & s2_vld),
        .d({sum[P_W], sum[P_W], pn}),
        .q(s3_q)
    );
    assign {carryout, overflow, p_q} = s3_q;

    dsp_pipe_reg #(.W(1), .EN(1)) u_vo (
        .clk(clk), .rst(rst), .ce(ce),
        .d(s2_vld),
        .q(out_valid)
    );

    assign p     = p_q;
    assign pcout = p_q;

endmodule
